// File: rtl/mem_responder_if.sv
// Cache-side request/response bundle for mem_responder.
// Three channels: i-cache read, d-cache read, d-cache write.
interface mem_responder_if #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 32
);
   logic                  i_rd_valid;
   logic [ADDR_WIDTH-1:0] i_rd_addr;
   logic                  i_rd_ready;
   logic                  i_rd_data_valid;
   logic [DATA_WIDTH-1:0] i_rd_data;

   logic                  d_rd_valid;
   logic [ADDR_WIDTH-1:0] d_rd_addr;
   logic                  d_rd_ready;
   logic                  d_rd_data_valid;
   logic [DATA_WIDTH-1:0] d_rd_data;

   logic                  d_wr_valid;
   logic [ADDR_WIDTH-1:0] d_wr_addr;
   logic [DATA_WIDTH-1:0] d_wr_data;
   logic                  d_wr_ready;

   modport master (
      output i_rd_valid, i_rd_addr,
      input  i_rd_ready, i_rd_data_valid, i_rd_data,
      output d_rd_valid, d_rd_addr,
      input  d_rd_ready, d_rd_data_valid, d_rd_data,
      output d_wr_valid, d_wr_addr, d_wr_data,
      input  d_wr_ready
   );

   modport slave (
      input  i_rd_valid, i_rd_addr,
      output i_rd_ready, i_rd_data_valid, i_rd_data,
      input  d_rd_valid, d_rd_addr,
      output d_rd_ready, d_rd_data_valid, d_rd_data,
      input  d_wr_valid, d_wr_addr, d_wr_data,
      output d_wr_ready
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates i-read, d-read, d-write channels,
// serves line-aligned read bursts after a fixed latency.
module mem_responder #(
   parameter int    ADDR_WIDTH = 24,
   parameter int    DATA_WIDTH = 32,
   parameter int    DEPTH_LOG2 = 16,
   parameter int    BURST_LEN  = 4,
   parameter int    LATENCY    = 4,
   parameter string INIT_FILE  = ""
) (
   input  logic            clk,
   input  logic            rst_n,
   mem_responder_if.slave  bus
);
   localparam int OFF    = $clog2(BURST_LEN);
   localparam int LINE_W = DEPTH_LOG2 - OFF;
   localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BURST
   } state_t;

   state_t state_q, state_nxt;

   logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

   logic [LINE_W-1:0]     line_q, line_nxt;
   logic [OFF-1:0]        beat_q, beat_nxt;
   logic [LAT_W-1:0]      cnt_q, cnt_nxt;
   logic                  chan_d_q, chan_d_nxt;

   logic                  issue;
   logic [OFF-1:0]        issue_k;
   logic [LINE_W-1:0]     issue_line;
   logic                  issue_d;
   logic                  start_rd;
   logic                  wr_fire;
   logic                  i_rdy, d_rdy, w_rdy;

   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;

   logic                  i_dv_q, d_dv_q;
   logic [DATA_WIDTH-1:0] i_data_q, d_data_q;

   logic                  unused_addr;

   always_comb begin
      state_nxt  = state_q;
      line_nxt   = line_q;
      cnt_nxt    = cnt_q;
      chan_d_nxt = chan_d_q;
      issue      = 1'b0;
      issue_k    = '0;
      issue_line = line_q;
      issue_d    = chan_d_q;
      start_rd   = 1'b0;
      wr_fire    = 1'b0;
      i_rdy      = 1'b0;
      d_rdy      = 1'b0;
      w_rdy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rst_n) begin
               if (bus.d_wr_valid) begin
                  w_rdy   = 1'b1;
                  wr_fire = 1'b1;
               end else if (bus.d_rd_valid) begin
                  d_rdy      = 1'b1;
                  start_rd   = 1'b1;
                  chan_d_nxt = 1'b1;
                  line_nxt   = bus.d_rd_addr[DEPTH_LOG2-1:OFF];
               end else if (bus.i_rd_valid) begin
                  i_rdy      = 1'b1;
                  start_rd   = 1'b1;
                  chan_d_nxt = 1'b0;
                  line_nxt   = bus.i_rd_addr[DEPTH_LOG2-1:OFF];
               end
            end
            if (start_rd) begin
               issue_line = line_nxt;
               issue_d    = chan_d_nxt;
               if (LATENCY == 1) begin
                  issue     = 1'b1;
                  state_nxt = BURST;
               end else begin
                  cnt_nxt   = LAT_W'(LATENCY - 2);
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               issue     = 1'b1;
               state_nxt = BURST;
            end else begin
               cnt_nxt = cnt_q - LAT_W'(1);
            end
         end
         BURST: begin
            if (beat_q == OFF'(BURST_LEN - 1)) begin
               state_nxt = IDLE;
            end else begin
               issue   = 1'b1;
               issue_k = beat_q + OFF'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      beat_nxt = issue ? issue_k : beat_q;
   end

   assign rd_idx  = {issue_line, issue_k};
   assign rd_word = mem[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         line_q   <= '0;
         beat_q   <= '0;
         cnt_q    <= '0;
         chan_d_q <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         line_q   <= line_nxt;
         beat_q   <= beat_nxt;
         cnt_q    <= cnt_nxt;
         chan_d_q <= chan_d_nxt;
      end
   end

   // Beat registers: data holds its last value once valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_dv_q   <= 1'b0;
         d_dv_q   <= 1'b0;
         i_data_q <= '0;
         d_data_q <= '0;
      end else begin
         i_dv_q <= issue && !issue_d;
         d_dv_q <= issue && issue_d;
         if (issue && issue_d) begin
            d_data_q <= rd_word;
         end
         if (issue && !issue_d) begin
            i_data_q <= rd_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[bus.d_wr_addr[DEPTH_LOG2-1:0]] <= bus.d_wr_data;
      end
   end

   assign bus.i_rd_ready      = i_rdy;
   assign bus.d_rd_ready      = d_rdy;
   assign bus.d_wr_ready      = w_rdy;
   assign bus.i_rd_data_valid = i_dv_q;
   assign bus.d_rd_data_valid = d_dv_q;
   assign bus.i_rd_data       = i_data_q;
   assign bus.d_rd_data       = d_data_q;

   assign unused_addr = ^{bus.i_rd_addr, bus.d_rd_addr, bus.d_wr_addr};
endmodule
